// File: rtl/fifo_wrapper.sv
// Single-clock circular buffer between the producers and the display consumer.
// One word is written per data_1_en cycle and one is popped per rd_tick pulse.
module fifo_wrapper #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              data_1_en,
    input  logic [DATA_W-1:0] data_1,
    input  logic              rd_tick,
    output logic [DATA_W-1:0] data_2,
    output logic              data_2_valid,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic [PTR_W:0]    count,
    output logic              overflow
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [DATA_W-1:0] r_data_2;
    logic              r_data_2_valid;
    logic              r_overflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_wr_drop;
    logic [PTR_W:0]    w_count_next;

    // Full/empty come from the pre-edge count, so a pop in the same cycle
    // never frees room for a write that arrives while full.
    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = data_1_en & ~w_full;
    assign w_rd_accept = rd_tick & ~w_empty;
    assign w_wr_drop   = data_1_en & w_full;

    always_comb begin
        w_count_next = r_count;
        unique case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + (PTR_W + 1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W + 1)'(1);
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_2       <= '0;
            r_data_2_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (flush) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_2_valid <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_data_2 <= r_mem[r_rd_ptr];
            end
            r_data_2_valid <= w_rd_accept;
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // Storage is not reset. A stray write into slot 0 during reset is harmless:
    // wr_ptr stays 0, so the first real write overwrites it before any read.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !flush) begin
            r_mem[r_wr_ptr] <= data_1;
        end
    end

    assign data_2       = r_data_2;
    assign data_2_valid = r_data_2_valid;
    assign buffer_full  = w_full;
    assign buffer_empty = w_empty;
    assign count        = r_count;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_fifo_wrapper.sv
// Directed bench for fifo_wrapper: a queue-based reference model tracks the
// buffer contents, and every popped word is compared against its front entry.
module tb_fifo_wrapper;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        rd_tick;
  logic [15:0] data_2;
  logic        data_2_valid;
  logic        buffer_full;
  logic        buffer_empty;
  logic [3:0]  count;
  logic        overflow;

  int vectors = 0;
  int errors  = 0;

  // Reference state: exp_q holds words written and not yet popped.
  logic [15:0] exp_q[$];
  logic [15:0] m_data_2;
  logic        m_valid;
  logic        m_over;

  fifo_wrapper #(.DEPTH(8), .PTR_W(3), .DATA_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .data_1_en    (data_1_en),
    .data_1       (data_1),
    .rd_tick      (rd_tick),
    .data_2       (data_2),
    .data_2_valid (data_2_valid),
    .buffer_full  (buffer_full),
    .buffer_empty (buffer_empty),
    .count        (count),
    .overflow     (overflow)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_data_2 = 16'h0000;
    m_valid  = 1'b0;
    m_over   = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".full"},  32'(buffer_full), 32'(exp_q.size() == 8));
    chk({tag, ".empty"}, 32'(buffer_empty), 32'(exp_q.size() == 0));
    chk({tag, ".valid"}, 32'(data_2_valid), 32'(m_valid));
    chk({tag, ".data_2"}, 32'(data_2), 32'(m_data_2));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_over));
  endtask

  // driver: apply one cycle of inputs, advance the model, check #1 after the edge
  task automatic cycle(input logic en, input logic [15:0] d, input logic tk,
                       input logic fl, input string tag);
    logic was_full;
    logic was_empty;
    data_1_en = en;
    data_1    = d;
    rd_tick   = tk;
    flush     = fl;
    was_full  = (exp_q.size() == 8);
    was_empty = (exp_q.size() == 0);
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      m_valid = 1'b0;
      m_over  = 1'b0;
    end else begin
      if (tk && !was_empty) begin
        m_data_2 = exp_q.pop_front();
        m_valid  = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (en && !was_full) exp_q.push_back(d);
      if (en && was_full) m_over = 1'b1;
    end
    check_model(tag);
    data_1_en = 1'b0;
    data_1    = 'x;
    rd_tick   = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 'x, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    data_1_en = 1'b0;
    data_1    = 'x;
    rd_tick   = 1'b0;
    model_reset();

    // reset held 3 cycles, released away from the active edge
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("rst.empty", 32'(buffer_empty), 32'd1);
    chk("rst.full", 32'(buffer_full), 32'd0);
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.valid", 32'(data_2_valid), 32'd0);
    chk("rst.data_2", 32'(data_2), 32'd0);
    chk("rst.overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;

    // fill and overflow
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, "fill");
    chk("fill.full", 32'(buffer_full), 32'd1);
    chk("fill.count8", 32'(count), 32'd8);
    cycle(1'b1, 16'h0009, 1'b0, 1'b0, "ovf");
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.count8", 32'(count), 32'd8);

    // drain order, rd_tick spaced 4 cycles apart
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 'x, 1'b1, 1'b0, "drain");
      chk("drain.word", 32'(data_2), 32'(i + 1));
      chk("drain.valid", 32'(data_2_valid), 32'd1);
      if (i == 7) chk("drain.empty_at_last", 32'(buffer_empty), 32'd1);
      idle("drain.gap");
      chk("drain.valid_1cyc", 32'(data_2_valid), 32'd0);
      idle("drain.gap");
      idle("drain.gap");
    end
    cycle(1'b0, 'x, 1'b1, 1'b0, "drain.extra");
    chk("drain.extra_novalid", 32'(data_2_valid), 32'd0);
    chk("drain.extra_hold", 32'(data_2), 32'h0008);

    // simultaneous read/write across pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h00A1 + 16'(i), 1'b0, 1'b0, "preload");
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 16'h0100 + 16'(i), 1'b1, 1'b0, "rw");
      chk("rw.count3", 32'(count), 32'd3);
    end

    // flush at count 5
    cycle(1'b1, 16'h0111, 1'b0, 1'b0, "to5");
    cycle(1'b1, 16'h0112, 1'b0, 1'b0, "to5");
    chk("pre_flush.count5", 32'(count), 32'd5);
    cycle(1'b0, 'x, 1'b0, 1'b1, "flush");
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.empty", 32'(buffer_empty), 32'd1);
    chk("flush.overflow", 32'(overflow), 32'd0);

    // full plus simultaneous read: pop happens, write dropped
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0, "refill");
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, "full_rw");
    chk("full_rw.data_2", 32'(data_2), 32'h0200);
    chk("full_rw.overflow", 32'(overflow), 32'd1);
    chk("full_rw.count7", 32'(count), 32'd7);
    for (int i = 0; i < 7; i++) cycle(1'b0, 'x, 1'b1, 1'b0, "full_rw.drain");
    idle("drain_done");
    chk("drain_done.empty", 32'(buffer_empty), 32'd1);
    chk("drain_done.novalid", 32'(data_2_valid), 32'd0);

    // async reset in the middle of a cycle
    cycle(1'b1, 16'h0301, 1'b0, 1'b0, "pre_rst");
    cycle(1'b1, 16'h0302, 1'b1, 1'b0, "pre_rst");
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst.count", 32'(count), 32'd0);
    chk("arst.empty", 32'(buffer_empty), 32'd1);
    chk("arst.full", 32'(buffer_full), 32'd0);
    chk("arst.valid", 32'(data_2_valid), 32'd0);
    chk("arst.data_2", 32'(data_2), 32'd0);
    chk("arst.overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // data path after reset
    cycle(1'b1, 16'h0401, 1'b0, 1'b0, "post_rst");
    cycle(1'b1, 16'h0402, 1'b1, 1'b0, "post_rst");
    cycle(1'b0, 'x, 1'b1, 1'b0, "post_rst");
    chk("post_rst.last", 32'(data_2), 32'h0402);
    idle("post_rst.idle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
